// File: rtl/ctrl_tx_frame_sequencer.sv
// Frame sequencer for the controller TX serializer: START -> per-byte DATA/PARITY -> STOP.
// All outputs are registered; mode_done is qualified by a first-cycle-after-entry guard.
module ctrl_tx_frame_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_use_start,
  input  logic              i_use_stop,
  input  logic [CNT_W-1:0]  i_byte_cnt,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_abort,
  input  logic              i_scl_pos_edge,
  input  logic              i_scl_neg_edge,
  input  logic              i_ser_mode_done,
  output logic              o_ser_en,
  output logic [2:0]        o_ser_mode,
  output logic [2:0]        o_ser_count,
  output logic              o_ser_count_done,
  output logic              o_regf_rd_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic              o_busy,
  output logic              o_done
);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PARITY = 3'd3, S_STOP = 3'd4, S_FINISH = 3'd5;
  localparam logic [2:0] M_START = 3'b000, M_SER = 3'b001, M_STOP = 3'b010, M_PAR = 3'b011;

  logic [2:0]        state_q, state_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic              use_stop_q, use_stop_d;
  logic              ser_en_q, ser_en_d;
  logic [2:0]        mode_q, mode_d;
  logic [2:0]        count_q, count_d;
  logic              cdone_q, cdone_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              enter_data;
  logic              qual;

  // A registered done from the previous mode may still be high on entry.
  assign qual = i_ser_mode_done && !first_q;

  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    bytes_d    = bytes_q;
    use_stop_d = use_stop_q;
    ser_en_d   = ser_en_q;
    mode_d     = mode_q;
    count_d    = count_q;
    cdone_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    enter_data = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req && (i_byte_cnt != '0)) begin
          bytes_d    = i_byte_cnt;
          use_stop_d = i_use_stop;
          addr_d     = i_base_addr;
          busy_d     = 1'b1;
          ser_en_d   = 1'b1;
          if (i_use_start) begin
            state_d = S_START;
            mode_d  = M_START;
            first_d = 1'b1;
          end else begin
            enter_data = 1'b1;
          end
        end
      end
      S_START: if (qual) enter_data = 1'b1;
      S_DATA: begin
        if (qual) begin
          state_d = S_PARITY;
          mode_d  = M_PAR;
          count_d = 3'd0;
          first_d = 1'b1;
        end else if (i_scl_neg_edge) begin
          if (count_q != 3'd0) count_d = count_q - 3'd1;
        end else if (i_scl_pos_edge && (count_q == 3'd0)) begin
          cdone_d = 1'b1;
        end
      end
      S_PARITY: begin
        if (qual) begin
          bytes_d = bytes_q - CNT_W'(1);
          if (bytes_q > CNT_W'(1)) begin
            addr_d     = addr_q + ADDR_W'(1);
            enter_data = 1'b1;
          end else if (use_stop_q) begin
            state_d = S_STOP;
            mode_d  = M_STOP;
            first_d = 1'b1;
          end else begin
            state_d  = S_FINISH;
            ser_en_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (qual) begin
          state_d  = S_FINISH;
          ser_en_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        mode_d  = M_START;
        count_d = 3'd7;
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        ser_en_d = 1'b0;
      end
    endcase
    if (enter_data) begin
      state_d = S_DATA;
      mode_d  = M_SER;
      count_d = 3'd7;
      rd_en_d = 1'b1;
      first_d = 1'b1;
    end
    // Abort wins over everything; the address is deliberately left alone.
    if (i_abort) begin
      state_d  = S_IDLE;
      first_d  = 1'b0;
      ser_en_d = 1'b0;
      mode_d   = M_START;
      count_d  = 3'd7;
      cdone_d  = 1'b0;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      bytes_q    <= '0;
      use_stop_q <= 1'b0;
      ser_en_q   <= 1'b0;
      mode_q     <= M_START;
      count_q    <= 3'd7;
      cdone_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      bytes_q    <= bytes_d;
      use_stop_q <= use_stop_d;
      ser_en_q   <= ser_en_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      cdone_q    <= cdone_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_ser_en         = ser_en_q;
  assign o_ser_mode       = mode_q;
  assign o_ser_count      = count_q;
  assign o_ser_count_done = cdone_q;
  assign o_regf_rd_en     = rd_en_q;
  assign o_regf_addr      = addr_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
endmodule
